// File: rtl/load_store_unit.sv
// Load/store unit: aligns store data and byte enables onto a DATA_WIDTH memory port,
// extracts and sign/zero-extends load data, and rejects misaligned accesses.
module load_store_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = DATA_WIDTH,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misalign,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_BYTES-1:0] mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [2:0]            off;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  we_q;

  logic                  accept;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_BYTES-1:0] wen_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  always_comb begin
    accept    = req_valid & req_ready;
    aligned   = 1'b1;
    wdata_rep = '0;
    wen_mask  = '0;
    case (req_size)
      2'd0: begin
        aligned   = 1'b1;
        wdata_rep = {(DATA_WIDTH/8){req_wdata[7:0]}};
        wen_mask  = DATA_BYTES'(1) << req_addr[2:0];
      end
      2'd1: begin
        aligned   = (req_addr[0] == 1'b0);
        wdata_rep = {(DATA_WIDTH/16){req_wdata[15:0]}};
        wen_mask  = DATA_BYTES'(3) << req_addr[2:0];
      end
      2'd2: begin
        aligned   = (req_addr[1:0] == 2'b00);
        wdata_rep = {(DATA_WIDTH/32){req_wdata[31:0]}};
        wen_mask  = DATA_BYTES'(15) << req_addr[2:0];
      end
      2'd3: begin
        aligned   = (req_addr[2:0] == 3'b000);
        wdata_rep = req_wdata;
        wen_mask  = '1;
      end
    endcase
  end

  // Memory data arrives during WAIT; move the addressed lane down to bit 0.
  always_comb begin
    shifted  = mem_rdata >> {off, 3'b000};
    load_ext = '0;
    case (size_q)
      2'd0: load_ext = {{(DATA_WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = {{(DATA_WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = {{(DATA_WIDTH-32){~uns_q & shifted[31]}}, shifted[31:0]};
      2'd3: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      off           <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wen       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            off       <= req_addr[2:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            we_q      <= req_we;
            mem_wdata <= wdata_rep;
            if (aligned) begin
              state   <= ISSUE;
              mem_wen <= req_we ? wen_mask : '0;
            end else begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end
          end
        end
        ISSUE: begin
          mem_wen <= '0;
          if (we_q) begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_rdata    <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state         <= RESP;
          resp_valid    <= 1'b1;
          resp_misalign <= 1'b0;
          resp_rdata    <= load_ext;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, signed/unsigned loads, misalignment,
// backpressure, reset mid-store and back-to-back throughput.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wen;
  logic [63:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DATA_BYTES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wen       (mem_wen),
    .mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for req_ready, presents one request across one edge, returns #1 after it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    int unsigned n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) check("accept_timeout", {63'd0, req_ready}, 64'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_resp_drop"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
    #3;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_mem_wen", {56'd0, mem_wen}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    #12 rst_n = 1'b1;
    step();
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // byte store at 0x43
    issue(1'b1, 2'd0, 1'b0, 64'h43, 64'hAB);
    check("sb_wen", {56'd0, mem_wen}, 64'h08);
    check("sb_wdata", mem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    check("sb_addr", mem_addr, 64'h43);
    check("sb_not_ready", {63'd0, req_ready}, 64'd0);
    check("sb_no_resp_yet", {63'd0, resp_valid}, 64'd0);
    step();
    check("sb_wen_off", {56'd0, mem_wen}, 64'h00);
    check("sb_resp_valid", {63'd0, resp_valid}, 64'd1);
    check("sb_misalign", {63'd0, resp_misalign}, 64'd0);
    check("sb_rdata", resp_rdata, 64'd0);
    handshake("sb");

    // half store at 0x0A
    issue(1'b1, 2'd1, 1'b0, 64'h0A, 64'h1234_5678);
    check("sh_wen", {56'd0, mem_wen}, 64'h0C);
    check("sh_wdata", mem_wdata, 64'h5678_5678_5678_5678);
    step();
    check("sh_resp_valid", {63'd0, resp_valid}, 64'd1);
    handshake("sh");

    // signed then unsigned half load at 0x106
    mem_rdata = 64'h8001_0000_0000_0000;
    issue(1'b0, 2'd1, 1'b0, 64'h106, 64'd0);
    check("lh_wen_issue", {56'd0, mem_wen}, 64'h00);
    step();
    check("lh_wait_no_resp", {63'd0, resp_valid}, 64'd0);
    check("lh_wait_wen", {56'd0, mem_wen}, 64'h00);
    check("lh_wait_addr", mem_addr, 64'h106);
    step();
    check("lh_resp_valid", {63'd0, resp_valid}, 64'd1);
    check("lh_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
    handshake("lh");
    issue(1'b0, 2'd1, 1'b1, 64'h106, 64'd0);
    step();
    check("lhu_wait_no_resp", {63'd0, resp_valid}, 64'd0);
    step();
    check("lhu_resp_valid", {63'd0, resp_valid}, 64'd1);
    check("lhu_rdata", resp_rdata, 64'h0000_0000_0000_8001);
    handshake("lhu");

    // signed byte load from the top lane
    mem_rdata = 64'h80FF_0000_0000_0000;
    issue(1'b0, 2'd0, 1'b0, 64'h107, 64'd0);
    step(); step();
    check("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    handshake("lb");

    // misaligned word load and double store
    issue(1'b0, 2'd2, 1'b0, 64'h102, 64'd0);
    check("mis_lw_valid", {63'd0, resp_valid}, 64'd1);
    check("mis_lw_flag", {63'd0, resp_misalign}, 64'd1);
    check("mis_lw_rdata", resp_rdata, 64'd0);
    check("mis_lw_wen", {56'd0, mem_wen}, 64'h00);
    handshake("mis_lw");
    issue(1'b1, 2'd3, 1'b0, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mis_sd_valid", {63'd0, resp_valid}, 64'd1);
    check("mis_sd_flag", {63'd0, resp_misalign}, 64'd1);
    check("mis_sd_wen", {56'd0, mem_wen}, 64'h00);
    handshake("mis_sd");

    // backpressure on a double load, with a competing request held up
    mem_rdata = 64'h1234;
    issue(1'b0, 2'd3, 1'b0, 64'h60, 64'd0);
    step(); step();
    check("bp_valid", {63'd0, resp_valid}, 64'd1);
    check("bp_rdata", resp_rdata, 64'h1234);
    req_we = 1'b1; req_size = 2'd0; req_addr = 64'h8; req_wdata = 64'h55; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_hold_rdata", resp_rdata, 64'h1234);
      check("bp_hold_ready", {63'd0, req_ready}, 64'd0);
      check("bp_hold_wen", {56'd0, mem_wen}, 64'h00);
    end
    req_valid = 1'b0;
    handshake("bp");
    check("bp_addr_kept", mem_addr, 64'h60);

    // reset during a store's ISSUE cycle
    issue(1'b1, 2'd2, 1'b0, 64'h10, 64'hDEAD_BEEF);
    check("rs_wen", {56'd0, mem_wen}, 64'h0F);
    check("rs_wdata", mem_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("rs_wen_dropped", {56'd0, mem_wen}, 64'h00);
    check("rs_ready_low", {63'd0, req_ready}, 64'd0);
    #1 rst_n = 1'b1;
    step();
    check("rs_no_resp", {63'd0, resp_valid}, 64'd0);
    check("rs_ready", {63'd0, req_ready}, 64'd1);
    step();
    check("rs_no_resp_late", {63'd0, resp_valid}, 64'd0);

    // back-to-back byte stores to 0x01
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 64'h01; req_wdata = 64'h5A;
    resp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("b2b_wen", {56'd0, mem_wen}, (i % 3 == 0) ? 64'h02 : 64'h00);
      check("b2b_ready", {63'd0, req_ready}, (i % 3 == 2) ? 64'd1 : 64'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the data path width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default DATA_WIDTH, giving the byte address width.
REQ-003 The block SHALL have parameter DATA_BYTES, default DATA_WIDTH/8, giving the byte lanes per word.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: zero-extend the load result.
REQ-011 The block SHALL have port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-012 The block SHALL have port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: a response is available.
REQ-014 The block SHALL have port resp_ready, input, 1 bit: the core consumes the response.
REQ-015 The block SHALL have port resp_rdata, output, DATA_WIDTH bits: extended load data; 0 for stores.
REQ-016 The block SHALL have port resp_misalign, output, 1 bit: the request was misaligned and not performed.
REQ-017 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: the data-memory byte address.
REQ-018 The block SHALL have port mem_wdata, output, DATA_WIDTH bits: lane-aligned store data.
REQ-019 The block SHALL have port mem_wen, output, DATA_BYTES bits: per-byte write enables.
REQ-020 The block SHALL have port mem_rdata, input, DATA_WIDTH bits: memory read data, registered by the memory, valid the cycle after the address is sampled.

Function
REQ-021 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 Acceptance (req_valid & req_ready at a rising edge) SHALL register the request: mem_addr = req_addr, and the byte offset off = req_addr[2:0].
REQ-023 An aligned request SHALL move IDLE->ISSUE.
REQ-024 A misaligned request SHALL move IDLE->RESP with resp_misalign=1 and resp_rdata=0, and SHALL NOT assert mem_wen.
REQ-025 Alignment SHALL be defined as: byte always aligned; half needs off[0]=0; word needs off[1:0]=0; double needs off=0.
REQ-026 mem_wen SHALL be nonzero only in ISSUE and only for stores: byte=1<<off, half=0x3<<off, word=0xF<<off, double=0xFF.
REQ-027 mem_wdata SHALL be the low size-bytes of req_wdata replicated across all lanes (byte x8, half x4, word x2, double as-is).
REQ-028 A store in ISSUE SHALL move to RESP at the next edge, giving resp_valid 2 edges after acceptance.
REQ-029 A load in ISSUE SHALL move to WAIT; in WAIT, mem_addr SHALL be held and mem_wen=0.
REQ-030 At the WAIT->RESP edge, the block SHALL capture resp_rdata = (mem_rdata >> 8*off), truncated to size, then sign-extended (or zero-extended if req_unsigned); load resp_valid SHALL therefore arrive 3 edges after acceptance.
REQ-031 In RESP, resp_valid=1; resp_rdata and resp_misalign SHALL be held stable until resp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-032 New req_valid SHALL be ignored outside IDLE; the earliest next acceptance is the edge after the response handshake (one bubble minimum).
REQ-033 mem_addr SHALL retain its last value in IDLE; mem_wen SHALL be 0 in IDLE, WAIT and RESP.

Reset
REQ-034 While rst_n=0, the block SHALL be asynchronously in state IDLE.
REQ-035 While rst_n=0, all outputs SHALL be 0: req_ready=0 during reset, and 1 from the first edge after release.
REQ-036 Reset during ISSUE SHALL drop mem_wen to 0 immediately and discard the pending request with no response.

Verification
REQ-037 Byte store: sb at addr 0x43, wdata 0xAB -> mem_wen=0x08 for exactly 1 cycle, mem_wdata=0xABAB_ABAB_ABAB_ABAB, resp_valid 2 edges after accept, resp_misalign=0.
REQ-038 Signed/unsigned half load: addr 0x106, mem_rdata=0x8001_0000_0000_0000 -> resp_rdata=0xFFFF_FFFF_FFFF_8001 signed, 0x0000_0000_0000_8001 unsigned, 3 edges after accept.
REQ-039 Misaligned access: word load at 0x102 -> mem_wen stays 0, resp_valid 1 edge after accept, resp_misalign=1, resp_rdata=0; a double store at 0x104 -> same behaviour with no write.
REQ-040 Backpressure: double load at 0x60 with mem_rdata=0x1234 and resp_ready=0 for 3 cycles -> resp_valid and resp_rdata=0x1234 held, req_ready=0, competing req_valid not accepted.
REQ-041 Reset mid-store: rst_n low during ISSUE -> mem_wen=0 before the next edge; after release, resp_valid=0 and req_ready=1.
REQ-042 Back-to-back: continuous req_valid and resp_ready=1 with stores -> one accept every 3 cycles (accept, ISSUE, RESP), and mem_wen pulses never adjacent.
